// File: rtl/image_stream_reader_pkg.sv
// rtl/image_stream_reader_pkg.sv - shared types and sizing for the image stream reader
package image_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int MAX_PAD = 3;

  // Padded side must hold max_img + 2*MAX_PAD; also used by the sliding-window configuration.
  function automatic int out_size_width(input int max_img);
    return $clog2(max_img + 2 * MAX_PAD + 1);
  endfunction

  localparam int OUT_SIZE_WIDTH_DEFAULT = out_size_width(28);

endpackage

// File: rtl/image_stream_reader_addr_gen.sv
// rtl/image_stream_reader_addr_gen.sv - raster position counters and running RAM address
module stream_addr_gen
  import image_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int IMG_SIZE_WIDTH = 5,
  parameter int PAD_WIDTH      = 2,
  parameter int OUT_SIZE_WIDTH = OUT_SIZE_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      advance,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [IMG_SIZE_WIDTH-1:0] img_size,
  input  logic [PAD_WIDTH-1:0]      pad,
  input  logic [OUT_SIZE_WIDTH-1:0] out_size,
  output logic                      interior,
  output logic                      last_pos,
  output logic [ADDR_WIDTH-1:0]     addr
);

  logic [OUT_SIZE_WIDTH-1:0] row_cnt;
  logic [OUT_SIZE_WIDTH-1:0] col_cnt;
  logic [OUT_SIZE_WIDTH-1:0] lo;
  logic [OUT_SIZE_WIDTH-1:0] hi;
  logic [OUT_SIZE_WIDTH-1:0] max_idx;

  assign lo       = OUT_SIZE_WIDTH'(pad);
  assign hi       = lo + OUT_SIZE_WIDTH'(img_size);
  assign max_idx  = out_size - OUT_SIZE_WIDTH'(1);
  assign interior = (row_cnt >= lo) && (row_cnt < hi) && (col_cnt >= lo) && (col_cnt < hi);
  assign last_pos = (row_cnt == max_idx) && (col_cnt == max_idx);

  // Interior reads arrive in raster order, so the image address is just a running count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      col_cnt <= '0;
      addr    <= '0;
    end else if (load) begin
      row_cnt <= '0;
      col_cnt <= '0;
      addr    <= base_addr;
    end else if (advance) begin
      if (col_cnt == max_idx) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + OUT_SIZE_WIDTH'(1);
      end else begin
        col_cnt <= col_cnt + OUT_SIZE_WIDTH'(1);
      end
      if (interior) begin
        addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/image_stream_reader.sv
// rtl/image_stream_reader.sv - reads a square image from RAM and streams it with optional zero border
module image_stream_reader
  import image_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_IMG_WIDTH  = 28,
  parameter int IMG_SIZE_WIDTH = 5,
  parameter int PAD_WIDTH      = 2,
  parameter int ADDR_WIDTH     = 10,
  parameter int OUT_SIZE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_in,
  input  logic [IMG_SIZE_WIDTH-1:0] img_size_in,
  input  logic [PAD_WIDTH-1:0]      pad_in,
  input  logic [ADDR_WIDTH-1:0]     base_addr_in,
  input  logic                      stall_in,
  output logic                      mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr_out,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data_in,
  output logic [DATA_WIDTH-1:0]     pixel_out,
  output logic                      pixel_valid_out,
  output logic [OUT_SIZE_WIDTH-1:0] out_size_out,
  output logic                      busy_out,
  output logic                      done_out
);

  state_t                    state;
  logic [IMG_SIZE_WIDTH-1:0] img_q;
  logic [PAD_WIDTH-1:0]      pad_q;
  logic                      start_ok;
  logic                      issue;
  logic                      interior;
  logic                      last_pos;
  logic                      s1_valid;
  logic                      s1_pad;

  assign start_ok      = (state == IDLE) && start_in;
  assign issue         = (state == ISSUE) && !stall_in;
  assign mem_rd_en_out = issue && interior;

  stream_addr_gen #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .IMG_SIZE_WIDTH(IMG_SIZE_WIDTH),
    .PAD_WIDTH     (PAD_WIDTH),
    .OUT_SIZE_WIDTH(OUT_SIZE_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .advance  (issue),
    .base_addr(base_addr_in),
    .img_size (img_q),
    .pad      (pad_q),
    .out_size (out_size_out),
    .interior (interior),
    .last_pos (last_pos),
    .addr     (mem_rd_addr_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      img_q        <= '0;
      pad_q        <= '0;
      out_size_out <= '0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            img_q        <= img_size_in;
            pad_q        <= pad_in;
            out_size_out <= OUT_SIZE_WIDTH'(img_size_in) + (OUT_SIZE_WIDTH'(pad_in) << 1);
            if (img_size_in == '0) begin
              done_out <= 1'b1;
            end else begin
              state    <= ISSUE;
              busy_out <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue && last_pos) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Nothing issues here, so the pipe empties two cycles after the last issue.
          if (done_out) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end else if (s1_valid) begin
            done_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid        <= 1'b0;
      s1_pad          <= 1'b0;
      pixel_valid_out <= 1'b0;
      pixel_out       <= '0;
    end else begin
      s1_valid        <= issue;
      s1_pad          <= !interior;
      pixel_valid_out <= s1_valid;
      pixel_out       <= (s1_valid && !s1_pad) ? mem_rd_data_in : '0;
    end
  end

endmodule

// File: tb/tb_image_stream_reader.sv
// tb/tb_image_stream_reader.sv - scoreboard bench for image_stream_reader
module tb_image_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_in = 1'b0;
  logic [4:0] img_size_in = '0;
  logic [1:0] pad_in = '0;
  logic [9:0] base_addr_in = '0;
  logic       stall_in = 1'b0;
  logic       mem_rd_en_out;
  logic [9:0] mem_rd_addr_out;
  logic [7:0] mem_rd_data_in = '0;
  logic [7:0] pixel_out;
  logic       pixel_valid_out;
  logic [5:0] out_size_out;
  logic       busy_out;
  logic       done_out;

  image_stream_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_in       (start_in),
    .img_size_in    (img_size_in),
    .pad_in         (pad_in),
    .base_addr_in   (base_addr_in),
    .stall_in       (stall_in),
    .mem_rd_en_out  (mem_rd_en_out),
    .mem_rd_addr_out(mem_rd_addr_out),
    .mem_rd_data_in (mem_rd_data_in),
    .pixel_out      (pixel_out),
    .pixel_valid_out(pixel_valid_out),
    .out_size_out   (out_size_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];
  always @(posedge clk) if (mem_rd_en_out) mem_rd_data_in <= ram[mem_rd_addr_out];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int c0 = 0;
  int job_pix, job_rd, done_cnt, done_cyc, first_cyc;
  bit done_valid;
  bit vhist [0:63];
  int exp_q [$];

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: pops the scoreboard whenever a pixel appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en_out) job_rd++;
      if (pixel_valid_out) begin
        if (cyc >= c0 && cyc - c0 < 64) vhist[cyc - c0] = 1'b1;
        if (job_pix == 0) first_cyc = cyc;
        job_pix++;
        if (exp_q.size() == 0) chk("extra_pixel", 1, 0);
        else chk("pixel", int'(pixel_out), exp_q.pop_front());
      end
      if (done_out) begin
        done_cnt++;
        done_cyc   = cyc;
        done_valid = pixel_valid_out;
      end
    end
  end

  // Reference: padded raster scan, interior pixels taken straight from the image in RAM.
  task automatic push_model(input int img, input int pad, input int base);
    int s = img + 2 * pad;
    for (int r = 0; r < s; r++)
      for (int c = 0; c < s; c++)
        if (r >= pad && r < pad + img && c >= pad && c < pad + img)
          exp_q.push_back(int'(ram[(base + (r - pad) * img + (c - pad)) % 1024]));
        else
          exp_q.push_back(0);
  endtask

  task automatic clear_job();
    job_pix = 0; job_rd = 0; done_cnt = 0; done_cyc = 0; first_cyc = 0; done_valid = 0;
    for (int i = 0; i < 64; i++) vhist[i] = 1'b0;
  endtask

  task automatic issue_start(input int img, input int pad, input int base);
    @(posedge clk); #1;
    img_size_in = 5'(img); pad_in = 2'(pad); base_addr_in = 10'(base); start_in = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start_in = 1'b0;
    img_size_in = 5'($urandom); pad_in = 2'($urandom); base_addr_in = 10'($urandom);
    chk("busy_after_start", int'(busy_out), (img > 0) ? 1 : 0);
  endtask

  // mode: 0 no stall, 1 random stall, 2 five-cycle stall after the 6th issue
  task automatic run_job(input int img, input int pad, input int base, input int mode, input bit extra);
    int s = img + 2 * pad;
    bit got = 0;
    clear_job();
    if (img > 0) push_model(img, pad, base);
    issue_start(img, pad, base);
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin got = 1; break; end
      stall_in = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2) ? (t >= 5 && t <= 9) : 1'b0;
      start_in = extra && (t == 4);
      if (extra && t == 4) img_size_in = 5'((img % 30) + 1);
    end
    stall_in = 1'b0; start_in = 1'b0;
    chk("done_seen", int'(got), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("pixel_count", job_pix, (img > 0) ? s * s : 0);
    chk("rd_count", job_rd, img * img);
    chk("queue_left", exp_q.size(), 0);
    chk("out_size", int'(out_size_out), s);
    chk("busy_idle", int'(busy_out), 0);
    if (img > 0) chk("done_with_last", int'(done_valid), 1);
    else chk("zero_done_latency", done_cyc - c0, 1);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, int'({mem_rd_en_out, mem_rd_addr_out, pixel_out, pixel_valid_out,
                    out_size_out, busy_out, done_out}), 0);
  endtask

  initial begin
    int cnt;
    for (int a = 0; a < 1024; a++) ram[a] = 8'(a);
    clear_job();
    #12;
    check_outputs_zero("reset_outputs");
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Plain stream
    run_job(3, 0, 16'h10, 0, 0);
    chk("plain_first_valid", first_cyc - c0, 3);
    chk("plain_done_cycle", done_cyc - c0, 11);

    // Padding
    run_job(2, 1, 16'h40, 0, 0);

    // Directed stall
    run_job(4, 0, 16'h80, 2, 0);
    chk("stall_trail0", int'(vhist[7]), 1);
    chk("stall_trail1", int'(vhist[8]), 1);
    cnt = 0;
    for (int i = 9; i <= 13; i++) cnt += int'(vhist[i]);
    chk("stall_gap", cnt, 0);
    cnt = 0;
    for (int i = 14; i <= 23; i++) cnt += int'(vhist[i]);
    chk("stall_resume", cnt, 10);

    // Start while busy is ignored
    run_job(5, 1, 16'h100, 0, 1);

    // Zero size
    run_job(0, 2, 16'h33, 0, 0);

    // Reset during row 2
    clear_job();
    push_model(4, 0, 16'h200);
    issue_start(4, 0, 16'h200);
    while (cyc < c0 + 10) @(posedge clk);
    #2; rst_n = 1'b0;
    #1; check_outputs_zero("abort_outputs");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    run_job(3, 0, 16'h10, 0, 0);
    chk("after_abort_first_valid", first_cyc - c0, 3);
    chk("after_abort_done_cycle", done_cyc - c0, 11);

    // Randomized jobs over random RAM contents
    for (int a = 0; a < 1024; a++) ram[a] = 8'($urandom);
    for (int j = 0; j < 10; j++)
      run_job($urandom_range(1, 8), $urandom_range(0, 3),
              (j % 3 == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023), 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/image_stream_reader.md
Name: image_stream_reader

Overview:
Pixel-stream source for the convolution datapath. On a start command it reads a square image of img_size x img_size pixels from synchronous-read image RAM. It can optionally surround the image with a zero-padding border. It emits the padded image in row-major order as a valid-qualified pixel stream, the exact format the sliding-window stage consumes (pixel plus pixel-valid, no ready).

Parameters:
DATA_WIDTH, 8, pixel width
MAX_IMG_WIDTH, 28, largest supported unpadded image side
IMG_SIZE_WIDTH, 5, width of img_size_in
PAD_WIDTH, 2, width of pad_in (pad 0..3)
ADDR_WIDTH, 10, image RAM address width
OUT_SIZE_WIDTH, 6, width of padded side (holds MAX_IMG_WIDTH+2*3)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start_in  in  1  start request, sampled only in IDLE
img_size_in  in  IMG_SIZE_WIDTH  unpadded image side
pad_in  in  PAD_WIDTH  zero border width
base_addr_in  in  ADDR_WIDTH  RAM address of pixel (0,0)
stall_in  in  1  pause issuing new positions
mem_rd_en_out  out  1  RAM read strobe
mem_rd_addr_out  out  ADDR_WIDTH  RAM read address
mem_rd_data_in  in  DATA_WIDTH  RAM data, valid 1 cycle after mem_rd_en_out
pixel_out  out  DATA_WIDTH  streamed pixel
pixel_valid_out  out  1  pixel_out qualifier
out_size_out  out  OUT_SIZE_WIDTH  latched img_size+2*pad, for downstream configuration
busy_out  out  1  job in progress
done_out  out  1  one-cycle end-of-job pulse

Behaviour:
- Reset: all outputs are 0; FSM goes to IDLE; counters and pipe valids are cleared. Asserting reset mid-job aborts the job with no done pulse.
- On start_in in IDLE, latch img_size, pad and base_addr, and set out_size_out = img+2*pad (S). Go to ISSUE; busy_out goes to 1 the next cycle. start_in while busy is ignored.
- If img_size_in == 0 at start, pulse done_out 1 cycle later, emit no pixels, return to IDLE.
- ISSUE: row_cnt and col_cnt (OUT_SIZE_WIDTH) walk 0..S-1 row-major. They advance one position per cycle when stall_in == 0 and hold when stall_in == 1.
- Interior position: pad <= row < pad+img and pad <= col < pad+img. An interior issue asserts mem_rd_en_out with address base + (row-pad)*img + (col-pad).
- The address comes from a running register incremented per interior read, with no multiplier. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Border position: no RAM read; a zero-flag travels down the pipe instead.
- Pipe: stage1 registers issue-valid and the pad flag. At stage2, pixel_out = pad ? 0 : mem_rd_data_in, registered. Fixed latency is 2 cycles from issue to pixel_valid_out for every position.
- stall_in blocks issue only. Up to 2 in-flight pixels still emerge, so pixel_valid_out may stay high for 2 cycles after stall rises.
- After issuing position (S-1,S-1), go to DRAIN. In DRAIN, once the pipe is empty, done_out pulses in the same cycle as the last pixel_valid_out. busy_out falls the next cycle and the FSM returns to IDLE.
- Exactly S*S valid pixels are produced per job, with no duplicates or gaps in order.
- A new start is accepted the first cycle back in IDLE.
- FSM states: IDLE, ISSUE, DRAIN.

Decomposition:
- Shared package: FSM state enum (IDLE/ISSUE/DRAIN), max pad constant 3, and OUT_SIZE_WIDTH derivation shared with the sliding-window configuration.
- One sub-module, stream_addr_gen: row/col counters, interior test and running address register.
- FSM and the 2-stage data pipe stay in the top module.

Test Plan:
- Plain stream: RAM[a] = a[7:0], img=3, pad=0, base=0x10, start at cycle 0. Expect pixels 0x10..0x18 valid on cycles 3..11, done_out on cycle 11, out_size_out=3.
- Padding: img=2, pad=1, base=0x40. Expect 16 pixels: 0,0,0,0, 0,0x40,0x41,0, 0,0x42,0x43,0, 0,0,0,0. Expect mem_rd_en_out pulsed exactly 4 times.
- Stall: img=4, pad=0; stall_in high for 5 cycles after the 6th issue. Expect 2 trailing valids, then a gap, then the remaining pixels contiguous and in order, 16 total.
- Start while busy: second start_in mid-job with different img is ignored. The first job completes unchanged with one done pulse.
- Zero size: img_size_in=0. Expect done_out 1 cycle after start, no pixel_valid_out, no mem reads.
- Reset mid-job: rst_n low during row 2. Expect outputs 0 immediately and no done pulse. After release, a fresh img=3 job behaves exactly as the plain-stream case.
